// File: rtl/uart_rx_bit_timer.sv
// Oversampling bit timer for the UART receiver: edge/bit counters, mid-bit majority-vote
// strobes and bit/frame completion pulses for a configurable frame geometry.
//
// state | meaning
// IDLE  | waiting for enable; config inputs are sampled on exit
// RUN   | counting edges and bits with the latched config
// ERR   | illegal config seen at enable; counters held at 0, cfg_err high
module uart_rx_bit_timer #(
  parameter int PRESC_W = 6,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic [CNT_W-1:0]   DATA_LEN,
  input  logic               PAR_EN,
  input  logic               STOP2,
  input  logic               enable,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [CNT_W-1:0]   bit_cnt,
  output logic [2:0]         sample_stb,
  output logic               bit_done,
  output logic               frame_done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t             state, state_n;
  logic [PRESC_W-1:0] p_q;
  logic [CNT_W-1:0]   l_q;
  logic               pe_q, s2_q;
  logic [PRESC_W-1:0] edge_n;
  logic [CNT_W-1:0]   bit_n;
  logic [PRESC_W-1:0] mid;
  logic [CNT_W-1:0]   frame_len;
  logic               cfg_ok, running, last_edge, last_bit;

  assign cfg_ok = (Prescale >= PRESC_W'(4)) &&
                  (DATA_LEN >= CNT_W'(5)) &&
                  (DATA_LEN <= CNT_W'(DATA_W));

  assign running   = (state == RUN);
  assign mid       = p_q >> 1;
  assign frame_len = CNT_W'(2) + l_q + CNT_W'(pe_q) + CNT_W'(s2_q);
  assign last_edge = (edge_cnt == p_q - PRESC_W'(1));
  assign last_bit  = (bit_cnt == frame_len - CNT_W'(1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (enable) state_n = cfg_ok ? RUN : ERR;
      RUN:     if (!enable) state_n = IDLE;
      ERR:     if (!enable) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Counters only advance while staying in RUN; every other path clears them.
  always_comb begin
    edge_n = '0;
    bit_n  = '0;
    if (running && enable) begin
      if (last_edge) begin
        bit_n = last_bit ? '0 : bit_cnt + CNT_W'(1);
      end else begin
        edge_n = edge_cnt + PRESC_W'(1);
        bit_n  = bit_cnt;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      p_q      <= '0;
      l_q      <= '0;
      pe_q     <= 1'b0;
      s2_q     <= 1'b0;
    end else begin
      state    <= state_n;
      edge_cnt <= edge_n;
      bit_cnt  <= bit_n;
      if (state == IDLE && enable) begin
        p_q  <= Prescale;
        l_q  <= DATA_LEN;
        pe_q <= PAR_EN;
        s2_q <= STOP2;
      end
    end
  end

  always_comb begin
    sample_stb[0] = running && (edge_cnt == mid - PRESC_W'(1));
    sample_stb[1] = running && (edge_cnt == mid);
    sample_stb[2] = running && (edge_cnt == mid + PRESC_W'(1));
    bit_done      = running && last_edge;
    frame_done    = bit_done && last_bit;
    cfg_err       = (state == ERR);
  end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Self-checking bench for uart_rx_bit_timer: a cycle model pushes expected outputs into a
// scoreboard as stimulus is applied; they are popped and compared after each clock edge.
module tb_uart_rx_bit_timer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Prescale;
  logic [3:0] DATA_LEN;
  logic       PAR_EN, STOP2, enable;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic [2:0] sample_stb;
  logic       bit_done, frame_done, cfg_err;

  int n_chk  = 0;
  int n_pass = 0;
  int cycle  = 0;

  logic [15:0] sb_q[$];

  // reference model state: 0=idle 1=run 2=err
  int m_st, m_e, m_b, m_p, m_l, m_pe, m_s2;

  int fd_cyc[$];
  int bd_cyc[$];

  uart_rx_bit_timer #(.PRESC_W(6), .DATA_W(8), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .Prescale(Prescale), .DATA_LEN(DATA_LEN), .PAR_EN(PAR_EN),
    .STOP2(STOP2), .enable(enable), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .sample_stb(sample_stb), .bit_done(bit_done), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: obs=%0d exp=%0d (cycle %0d)", tag, obs, exp, cycle);
  endtask

  function automatic logic [15:0] dut_vec();
    return {edge_cnt, bit_cnt, sample_stb, bit_done, frame_done, cfg_err};
  endfunction

  function automatic logic [15:0] model_vec();
    int fl, half;
    logic [2:0] stb;
    logic bd, fd;
    fl   = 2 + m_l + m_pe + m_s2;
    half = m_p / 2;
    stb  = 3'b000;
    bd   = 1'b0;
    fd   = 1'b0;
    if (m_st == 1) begin
      if (m_e == half - 1) stb = 3'b001;
      if (m_e == half)     stb = 3'b010;
      if (m_e == half + 1) stb = 3'b100;
      bd = (m_e == m_p - 1);
      fd = bd && (m_b == fl - 1);
    end
    return {6'(m_e), 4'(m_b), stb, bd, fd, (m_st == 2)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_e = 0; m_b = 0;
    m_p = 0; m_l = 0; m_pe = 0; m_s2 = 0;
  endtask

  task automatic model_step();
    int fl;
    if (m_st == 0) begin
      if (enable) begin
        m_p = Prescale; m_l = DATA_LEN; m_pe = PAR_EN; m_s2 = STOP2;
        m_st = (Prescale >= 4 && DATA_LEN >= 5 && DATA_LEN <= 8) ? 1 : 2;
      end
      m_e = 0; m_b = 0;
    end else if (!enable) begin
      m_st = 0; m_e = 0; m_b = 0;
    end else if (m_st == 1) begin
      fl = 2 + m_l + m_pe + m_s2;
      if (m_e == m_p - 1) begin
        m_e = 0;
        m_b = (m_b == fl - 1) ? 0 : m_b + 1;
      end else begin
        m_e = m_e + 1;
      end
    end
  endtask

  // One clock: predict, push, let the edge happen, then pop and compare at the negedge.
  task automatic cyc();
    logic [15:0] exp;
    model_step();
    sb_q.push_back(model_vec());
    @(posedge CLK);
    @(negedge CLK);
    cycle++;
    exp = sb_q.pop_front();
    check_val("outputs", int'(dut_vec()), int'(exp));
    if (frame_done) fd_cyc.push_back(cycle);
    if (bit_done) bd_cyc.push_back(cycle);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic config_in(input int p, input int l, input int pe, input int s2);
    Prescale = 6'(p); DATA_LEN = 4'(l); PAR_EN = 1'(pe); STOP2 = 1'(s2);
  endtask

  initial begin
    int t0;
    int found;
    RST = 1'b1;
    enable = 1'b0;
    config_in(8, 8, 1, 0);
    model_reset();
    #1;
    check_val("reset_outputs", int'(dut_vec()), 0);
    @(negedge CLK);
    RST = 1'b0;
    run(3);
    check_val("idle_quiet", int'(dut_vec()), 0);

    // P=8 L=8 PE=1 S2=0 -> 11 bits of 8 edges
    config_in(8, 8, 1, 0);
    enable = 1'b1;
    t0 = cycle;
    fd_cyc.delete(); bd_cyc.delete();
    run(89);
    check_val("t1_fd_count", fd_cyc.size(), 1);
    if (fd_cyc.size() > 0) check_val("t1_fd_cycle", fd_cyc[0] - t0, 88);
    check_val("t1_bd_count", bd_cyc.size(), 11);
    if (bd_cyc.size() > 1) check_val("t1_bd_period", bd_cyc[1] - bd_cyc[0], 8);
    check_val("t1_bit_after_fd", int'(bit_cnt), 0);
    enable = 1'b0;
    run(2);

    // P=16 L=5 PE=0 S2=1 -> 8 bits, three back-to-back frames
    config_in(16, 5, 0, 1);
    enable = 1'b1;
    t0 = cycle;
    fd_cyc.delete();
    run(3 * 128 + 1);
    check_val("t2_fd_count", fd_cyc.size(), 3);
    if (fd_cyc.size() == 3) begin
      check_val("t2_fd_first", fd_cyc[0] - t0, 128);
      check_val("t2_fd_gap1", fd_cyc[1] - fd_cyc[0], 128);
      check_val("t2_fd_gap2", fd_cyc[2] - fd_cyc[1], 128);
    end
    enable = 1'b0;
    run(1);

    // P=5 L=7: strobes at 1/2/3; mid-frame Prescale change is ignored until re-enable
    config_in(5, 7, 0, 0);
    enable = 1'b1;
    run(3);
    check_val("t3_stb_edge2", {26'd0, edge_cnt}, 2);
    check_val("t3_stb_mid", int'(sample_stb), 3'b010);
    Prescale = 6'd9;
    bd_cyc.delete();
    run(20);
    if (bd_cyc.size() > 1) check_val("t3_period_kept", bd_cyc[1] - bd_cyc[0], 5);
    else check_val("t3_bd_seen", bd_cyc.size(), 2);
    enable = 1'b0;
    run(1);
    enable = 1'b1;
    bd_cyc.delete();
    run(20);
    if (bd_cyc.size() > 1) check_val("t3_period_new", bd_cyc[1] - bd_cyc[0], 9);
    else check_val("t3_bd_seen_new", bd_cyc.size(), 2);
    enable = 1'b0;
    run(1);

    // illegal configs
    config_in(3, 8, 0, 0);
    enable = 1'b1;
    run(5);
    check_val("t4_err_presc", int'(cfg_err), 1);
    check_val("t4_cnt_zero", int'(edge_cnt) + int'(bit_cnt), 0);
    enable = 1'b0;
    run(1);
    check_val("t4_err_clear", int'(cfg_err), 0);
    config_in(8, 4, 0, 0);
    enable = 1'b1;
    run(3);
    check_val("t4_err_len4", int'(cfg_err), 1);
    enable = 1'b0;
    run(1);
    config_in(8, 9, 0, 0);
    enable = 1'b1;
    run(2);
    check_val("t4_err_len9", int'(cfg_err), 1);
    enable = 1'b0;
    run(1);

    // drop enable at bit 4 edge 2, then restart
    config_in(6, 6, 1, 1);
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      cyc();
      if (bit_cnt == 4'd4 && edge_cnt == 6'd2) found = 1;
    end
    check_val("t5_reached", found, 1);
    enable = 1'b0;
    run(1);
    check_val("t5_cleared", int'(edge_cnt) + int'(bit_cnt), 0);
    enable = 1'b1;
    run(8);
    check_val("t5_restart_bit", int'(bit_cnt), 1);

    // async reset mid-frame
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      cyc();
      if (bit_cnt == 4'd6) found = 1;
    end
    check_val("t6_reached", found, 1);
    #2;
    RST = 1'b1;
    #1;
    check_val("t6_async_zero", int'(dut_vec()), 0);
    model_reset();
    @(negedge CLK);
    cycle++;
    RST = 1'b0;
    run(1);
    check_val("t6_run_from0", int'(edge_cnt), 0);
    run(7);
    check_val("t6_counting", int'(edge_cnt) + 6 * int'(bit_cnt), 7);

    // enable falling on a frame_done cycle
    config_in(4, 5, 0, 0);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      cyc();
      if (frame_done) found = 1;
    end
    check_val("t7_fd_seen", found, 1);
    enable = 1'b0;
    run(2);
    check_val("t7_idle_after", int'(dut_vec()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
